// File: rtl/red_pkg.sv
// -----------------------------------------------------------------------------
// red_pkg
// Shared declarations for the lane-reduction accumulator.
//
// Contents:
//   DEF_DATA_W / DEF_LANE_W : default operand width and lane width
//   state_t                 : controller states (IDLE, RUN, DONE)
//   idx_width()             : width of a lane index that can address n lanes.
//                             Never narrower than one bit.
// -----------------------------------------------------------------------------
package red_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_LANE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-lane configuration still needs a one-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : red_pkg

// File: rtl/red_lane_add.sv
// -----------------------------------------------------------------------------
// red_lane_add
// Exact sum of two LANE_W-bit lanes. The sum is one bit wider than a lane, so
// it never wraps or saturates. The block is purely combinational.
//
// Ports:
//   a, b : in  [LANE_W-1:0] lane operands
//   sgn  : in               1 = operands are two's complement, 0 = unsigned
//   sum  : out [LANE_W:0]   exact sum. It is signed when sgn = 1.
// -----------------------------------------------------------------------------
module red_lane_add
    import red_pkg::*;
#(
    parameter int LANE_W = DEF_LANE_W
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    input  logic              sgn,
    output logic [LANE_W:0]   sum
);

    logic [LANE_W:0] w_a_ext;
    logic [LANE_W:0] w_b_ext;

    // Widen by one bit. The MSB is copied when signed and zero-filled when
    // unsigned. An (L+1)-bit sum then holds every case:
    //   signed range:   -2^L .. 2^L-2
    //   unsigned range:  0   .. 2^(L+1)-2
    assign w_a_ext = {sgn & a[LANE_W-1], a};
    assign w_b_ext = {sgn & b[LANE_W-1], b};
    assign sum     = w_a_ext + w_b_ext;

endmodule : red_lane_add

// File: rtl/red_accum.sv
// -----------------------------------------------------------------------------
// red_accum
// Multi-cycle lane reduction. A start latches operands A and B, which hold
// packed lanes with lane 0 in the LSBs. Each RUN cycle then adds the lane pair
// at the current index into an accumulator. That accumulator is wide enough
// that it can never overflow. After the last lane, the controller spends one
// cycle in DONE and pulses done. The extended sum is held on result.
//
// Ports:
//   clk    : in                sole clock, rising edge
//   rst    : in                synchronous active-high reset; beats start
//   start  : in                begin a reduction (honoured in IDLE or DONE)
//   sgn    : in                1 = signed lanes, 0 = unsigned lanes
//   A, B   : in  [DATA_W-1:0]  packed lane operands
//   busy   : out               reduction in progress (RUN only)
//   done   : out               one-cycle pulse; result valid
//   result : out [DATA_W-1:0]  reduced sum. It is extended per sgn and held
//                              until the next DONE entry.
//
// Timing: done rises N_LANES rising edges after the edge that sampled start.
// -----------------------------------------------------------------------------
module red_accum
    import red_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANE_W = DEF_LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sgn,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int N_LANES = DATA_W / LANE_W;
    localparam int ACC_W   = LANE_W + 1 + $clog2(N_LANES);
    localparam int IDX_W   = idx_width(N_LANES);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

    // ---------------------------------------------------------------- state
    state_t             r_state;
    logic [DATA_W-1:0]  r_a;
    logic [DATA_W-1:0]  r_b;
    logic               r_sgn;
    logic [ACC_W-1:0]   r_acc;
    logic [IDX_W-1:0]   r_idx;
    logic [DATA_W-1:0]  r_result;

    // ---------------------------------------------------------- comb wires
    state_t             w_state_next;
    logic               w_accept;
    logic               w_last;
    logic [DATA_W-1:0]  w_shift_a;
    logic [DATA_W-1:0]  w_shift_b;
    logic [LANE_W-1:0]  w_lane_a;
    logic [LANE_W-1:0]  w_lane_b;
    logic [LANE_W:0]    w_lane_sum;
    logic [ACC_W-1:0]   w_sum_ext;
    logic [ACC_W-1:0]   w_acc_next;
    logic [DATA_W-1:0]  w_result_ext;

    // Lane selection. Shift the current lane down to bit 0, then keep the low
    // LANE_W bits. One adder is reused for every lane.
    assign w_shift_a = r_a >> (int'(r_idx) * LANE_W);
    assign w_shift_b = r_b >> (int'(r_idx) * LANE_W);
    assign w_lane_a  = w_shift_a[LANE_W-1:0];
    assign w_lane_b  = w_shift_b[LANE_W-1:0];
    assign w_last    = (r_idx == LAST_IDX);

    red_lane_add #(
        .LANE_W (LANE_W)
    ) u_lane_add (
        .a   (w_lane_a),
        .b   (w_lane_b),
        .sgn (r_sgn),
        .sum (w_lane_sum)
    );

    // Extend the lane sum and the new accumulator value according to the
    // latched sign mode. A size cast of a signed operand sign-extends it.
    always_comb begin
        // NOTE: every variable written here gets a value before any branch.
        // A path that skips an assignment would otherwise infer a latch.
        w_sum_ext    = '0;
        w_acc_next   = '0;
        w_result_ext = '0;
        if (r_sgn) begin
            w_sum_ext    = ACC_W'($signed(w_lane_sum));
            w_acc_next   = r_acc + w_sum_ext;
            w_result_ext = DATA_W'($signed(w_acc_next));
        end else begin
            w_sum_ext    = ACC_W'(w_lane_sum);
            w_acc_next   = r_acc + w_sum_ext;
            w_result_ext = DATA_W'(w_acc_next);
        end
    end

    // Next-state and output decode.
    // start is honoured in IDLE and in DONE, which allows back-to-back
    // operation. In RUN it is ignored.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // All state lives here. rst is checked first, so it beats start, and it
    // abandons a reduction that is in flight before any done pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register samples the values
        // from before this edge. Order inside the block does not matter.
        if (rst) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sgn    <= 1'b0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a   <= A;
                r_b   <= B;
                r_sgn <= sgn;
                r_acc <= '0;
                r_idx <= '0;
            end else if (r_state == RUN) begin
                r_acc <= w_acc_next;
                r_idx <= r_idx + IDX_W'(1);
                // The edge that folds in the last lane is the DONE-entry edge.
                if (w_last) begin
                    r_result <= w_result_ext;
                end
            end
        end
    end

    assign result = r_result;

endmodule : red_accum

// File: tb/tb_red_accum.sv
// -----------------------------------------------------------------------------
// tb_red_accum
// Directed bench for red_accum. It drives two instances:
//   u_dut16 : default configuration (16-bit operands, 8-bit lanes)
//   u_dut32 : 32-bit operands, 4-bit lanes
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_red_accum;

    logic        clk = 1'b0;
    logic        rst;

    logic        start0, sgn0;
    logic [15:0] a0, b0;
    logic        busy0, done0;
    logic [15:0] result0;

    logic        start1, sgn1;
    logic [31:0] a1, b1;
    logic        busy1, done1;
    logic [31:0] result1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    red_accum u_dut16 (
        .clk    (clk),
        .rst    (rst),
        .start  (start0),
        .sgn    (sgn0),
        .A      (a0),
        .B      (b0),
        .busy   (busy0),
        .done   (done0),
        .result (result0)
    );

    red_accum #(
        .DATA_W (32),
        .LANE_W (4)
    ) u_dut32 (
        .clk    (clk),
        .rst    (rst),
        .start  (start1),
        .sgn    (sgn1),
        .A      (a1),
        .B      (b1),
        .busy   (busy1),
        .done   (done1),
        .result (result1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? busy1 : busy0;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? done1 : done0;
    endfunction

    function automatic logic [31:0] get_result(input bit sel);
        return sel ? result1 : {16'h0000, result0};
    endfunction

    task automatic drive(input bit sel, input logic st, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            start1 = st; sgn1 = s; a1 = a; b1 = b;
        end else begin
            start0 = st; sgn0 = s; a0 = a[15:0]; b0 = b[15:0];
        end
    endtask

    task automatic set_start(input bit sel, input logic st);
        if (sel) start1 = st;
        else     start0 = st;
    endtask

    // One complete reduction. exp_lat counts rising edges from the edge that
    // samples start to the first falling edge where done is seen.
    task automatic run_op(input bit sel, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input string tag);
        int edges;
        logic [31:0] held;
        @(negedge clk);
        drive(sel, 1'b1, s, a, b);
        @(negedge clk);
        set_start(sel, 1'b0);
        check({tag, ".busy_run"}, 32'(get_busy(sel)), 32'd1);
        edges = 0;
        while (!get_done(sel) && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check({tag, ".latency"}, edges, exp_lat);
        check({tag, ".result"}, get_result(sel), exp);
        check({tag, ".busy_done"}, 32'(get_busy(sel)), 32'd0);
        held = get_result(sel);
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(get_done(sel)), 32'd0);
        check({tag, ".hold"}, get_result(sel), exp);
        if (held !== exp) begin
            // Keeps the held value meaningful even when the result check failed.
            check({tag, ".hold_prev"}, get_result(sel), held);
        end
    endtask

    initial begin : main
        int edges;
        int done_seen;

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("rst.busy16",   32'(busy0), 32'd0);
        check("rst.done16",   32'(done0), 32'd0);
        check("rst.result16", {16'h0, result0}, 32'h0);
        check("rst.busy32",   32'(busy1), 32'd0);
        check("rst.done32",   32'(done1), 32'd0);
        check("rst.result32", result1, 32'h0);

        // Reset beats a simultaneous start.
        drive(1'b0, 1'b1, 1'b1, 32'h7F7F, 32'h0101);
        @(negedge clk);
        check("rst_prio.busy", 32'(busy0), 32'd0);
        check("rst_prio.done", 32'(done0), 32'd0);
        start0 = 1'b0;
        rst    = 1'b0;

        // Hand-computed reductions, default configuration.
        run_op(1'b0, 1'b1, 32'h7F7F, 32'h0101, 32'h0000_0100, 2, "s_7f_01");
        run_op(1'b0, 1'b1, 32'h8080, 32'h8080, 32'h0000_FE00, 2, "s_min");
        run_op(1'b0, 1'b0, 32'hFFFF, 32'hFFFF, 32'h0000_03FC, 2, "u_max");
        run_op(1'b0, 1'b1, 32'h05FF, 32'h80FE, 32'h0000_FF82, 2, "s_mix");
        run_op(1'b0, 1'b0, 32'h05FF, 32'h80FE, 32'h0000_0282, 2, "u_mix");

        // Wide configuration: 8 lanes of 4 bits.
        run_op(1'b1, 1'b0, 32'h1111_1111, 32'h1111_1111, 32'h0000_0010, 8, "w32_u");
        run_op(1'b1, 1'b1, 32'h8888_8888, 32'h8888_8888, 32'hFFFF_FF80, 8, "w32_smin");

        // start pulsed again during RUN, with new operands: it must be ignored.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 32'h7F7F, 32'h0101);
        @(negedge clk);                        // RUN, lane 0 pending
        drive(1'b0, 1'b1, 1'b0, 32'hFFFF, 32'hFFFF);
        @(negedge clk);                        // RUN, lane 1 pending
        start0 = 1'b0;
        check("ign.busy", 32'(busy0), 32'd1);
        @(negedge clk);
        check("ign.done", 32'(done0), 32'd1);
        check("ign.result", {16'h0, result0}, 32'h0000_0100);
        @(negedge clk);
        check("ign.idle_busy", 32'(busy0), 32'd0);
        check("ign.idle_done", 32'(done0), 32'd0);

        // Reset in the middle of RUN abandons the reduction.
        drive(1'b0, 1'b1, 1'b0, 32'hFFFF, 32'hFFFF);
        @(negedge clk);                        // RUN
        start0 = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("midrst.busy",   32'(busy0), 32'd0);
        check("midrst.done",   32'(done0), 32'd0);
        check("midrst.result", {16'h0, result0}, 32'h0);
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done0) done_seen++;
        end
        check("midrst.no_done", done_seen, 0);
        check("midrst.idle", 32'(busy0), 32'd0);

        // start held high through DONE: the second reduction follows at once.
        drive(1'b0, 1'b1, 1'b1, 32'h7F7F, 32'h0101);
        @(negedge clk);
        edges = 0;
        while (!done0 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check("b2b.lat1", edges, 2);
        check("b2b.res1", {16'h0, result0}, 32'h0000_0100);
        a0 = 16'h8080;
        b0 = 16'h8080;
        @(negedge clk);                        // second operation accepted
        check("b2b.gap_done", 32'(done0), 32'd0);
        check("b2b.gap_busy", 32'(busy0), 32'd1);
        start0 = 1'b0;
        edges = 0;
        while (!done0 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check("b2b.lat2", edges, 2);
        check("b2b.res2", {16'h0, result0}, 32'h0000_FE00);
        @(negedge clk);
        check("b2b.pulse", 32'(done0), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_red_accum

// File: doc/red_accum.md
RED_ACCUM -- requirements
Module: red_accum

Interface
REQ-001 SHALL have parameter DATA_W, default 16: operand and result width.
REQ-002 SHALL have parameter LANE_W, default 8: lane width; DATA_W % LANE_W == 0, LANE_W >= 2.
REQ-003 SHALL have derived constant N_LANES = DATA_W/LANE_W and ACC_W = LANE_W + 1 + clog2(N_LANES); DATA_W >= ACC_W.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  request a new reduction.
REQ-007 SHALL have port sgn  in  1  1 = signed lanes, 0 = unsigned lanes.
REQ-008 SHALL have ports A, B  in  DATA_W  operands, packed lanes, lane 0 = LSBs.
REQ-009 SHALL have port busy  out  1  reduction in progress.
REQ-010 SHALL have port done  out  1  single-cycle result-valid pulse.
REQ-011 SHALL have port result  out  DATA_W  reduced sum, extended to DATA_W.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; on acceptance, latch A, B and sgn, clear accumulator and lane index, go to RUN.
REQ-014 SHALL ignore start while in RUN; latched operands SHALL be unaffected.
REQ-015 SHALL, each RUN cycle, form the exact (LANE_W+1)-bit sum of lane[idx] of A and B (sign-extended operands if sgn, zero-extended otherwise), with no wrap or saturation.
REQ-016 SHALL extend that lane sum to ACC_W per sgn, add it into the ACC_W-bit accumulator and increment idx.
REQ-017 SHALL move RUN -> DONE on the edge that accumulates lane N_LANES-1; the accumulator cannot overflow by construction.
REQ-018 SHALL assert done for exactly one cycle in DONE, N_LANES edges after the edge that sampled start.
REQ-019 SHALL drive result = accumulator sign-extended (sgn) or zero-extended (!sgn) to DATA_W, updated on the DONE-entry edge and held until the next DONE entry or reset.
REQ-020 SHALL assert busy in RUN only, so busy is 0 in IDLE and DONE.
REQ-021 SHALL move DONE -> IDLE after one cycle when start is low, and DONE -> RUN when start is high (back-to-back).
REQ-022 SHALL, for N_LANES == 1, still take one RUN cycle.

Reset
REQ-023 SHALL, on rst high at a clock edge, enter IDLE and set busy = 0, done = 0, result = 0, accumulator = 0, idx = 0.
REQ-024 SHALL give rst priority over start in the same cycle.
REQ-025 SHALL abandon a reset mid-RUN reduction with no done pulse.

Structure
REQ-026 SHALL place the FSM state enum and default DATA_W/LANE_W constants in shared package red_pkg.
REQ-027 SHALL instantiate one sub-module red_lane_add (parameter LANE_W): inputs a, b, sgn; output the exact LANE_W+1 bit sum, reused each RUN cycle.
REQ-028 SHALL keep all state in one always block with synchronous reset; sums SHALL be combinational.

Verification
REQ-029 SHALL cover: defaults, sgn = 1, A = 0x7F7F, B = 0x0101 -> result 0x0100, done 2 edges after start.
REQ-030 SHALL cover: sgn = 1, A = 0x8080, B = 0x8080 -> result 0xFE00 (-512).
REQ-031 SHALL cover: sgn = 0, A = 0xFFFF, B = 0xFFFF -> result 0x03FC (1020).
REQ-032 SHALL cover: start re-pulsed during RUN with new operands -> ignored, first result unchanged; rst mid-RUN -> busy = 0, result = 0, no done.
REQ-033 SHALL cover: DATA_W = 32, LANE_W = 4, sgn = 0, A = B = 0x11111111 -> result 0x00000010, done 8 edges after start.
REQ-034 SHALL cover: start held high through DONE -> second reduction begins immediately, with a done pulse per operation.
